// File: rtl/data_stack.sv
// rtl/data_stack.sv - operand stack with registered T/N and array-backed deeper entries
module data_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 stackOP,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           top,
    output logic [WIDTH-1:0]           second,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AD = DEPTH - 2;
    localparam int PW = $clog2(AD + 1);

    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_BINOP = 3'd2;
    localparam logic [2:0] OP_POP   = 3'd3;
    localparam logic [2:0] OP_POP2  = 3'd4;
    localparam logic [2:0] OP_SWAP  = 3'd5;

    // sp counts array entries, always max(count-2, 0)
    logic [PW-1:0]    sp;
    logic [WIDTH-1:0] mem [AD];
    logic [WIDTH-1:0] arr_top;
    logic [WIDTH-1:0] arr_next;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign arr_top  = (sp != '0)       ? mem[sp - PW'(1)] : '0;
    assign arr_next = (sp > PW'(1))    ? mem[sp - PW'(2)] : '0;

    always_ff @(posedge clk) begin
        if (reset && stackOP == OP_PUSH && !full && count >= CW'(2))
            mem[sp] <= second;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count     <= '0;
            sp        <= '0;
            top       <= '0;
            second    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (stackOP)
                OP_PUSH: begin
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        second <= top;
                        top    <= din;
                        count  <= count + CW'(1);
                        if (count >= CW'(2))
                            sp <= sp + PW'(1);
                    end
                end
                OP_BINOP: begin
                    if (count < CW'(2)) begin
                        underflow <= 1'b1;
                    end else begin
                        top    <= din;
                        second <= arr_top;
                        count  <= count - CW'(1);
                        if (sp != '0)
                            sp <= sp - PW'(1);
                    end
                end
                OP_POP: begin
                    if (count < CW'(1)) begin
                        underflow <= 1'b1;
                    end else begin
                        // with count==1, second is already 0 so T clears
                        top    <= second;
                        second <= arr_top;
                        count  <= count - CW'(1);
                        if (sp != '0)
                            sp <= sp - PW'(1);
                    end
                end
                OP_POP2: begin
                    if (count < CW'(2)) begin
                        underflow <= 1'b1;
                    end else begin
                        top    <= arr_top;
                        second <= arr_next;
                        count  <= count - CW'(2);
                        sp     <= (sp >= PW'(2)) ? sp - PW'(2) : '0;
                    end
                end
                OP_SWAP: begin
                    if (count < CW'(2)) begin
                        underflow <= 1'b1;
                    end else begin
                        top    <= second;
                        second <= top;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_data_stack.sv
// tb/tb_data_stack.sv - scoreboard bench for data_stack against a queue-based stack model
module tb_data_stack;
    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic [2:0]       stack_op;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] second;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stackOP(stack_op), .din(din),
        .top(top), .second(second), .count(count), .empty(empty),
        .full(full), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] top;
        logic [WIDTH-1:0] second;
        int               count;
        logic             empty;
        logic             full;
        logic             ovf;
        logic             unf;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] stk[$];
    logic             m_ovf;
    logic             m_unf;
    int               passed;
    int               total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model(input logic rst, input logic [2:0] o, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int n;
        n = stk.size();
        if (!rst) begin
            stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            case (o)
                3'd1: if (n == DEPTH) m_ovf = 1'b1; else stk.push_back(d);
                3'd2: if (n < 2) m_unf = 1'b1;
                      else begin a = stk.pop_back(); a = stk.pop_back(); stk.push_back(d); end
                3'd3: if (n < 1) m_unf = 1'b1; else a = stk.pop_back();
                3'd4: if (n < 2) m_unf = 1'b1;
                      else begin a = stk.pop_back(); a = stk.pop_back(); end
                3'd5: if (n < 2) m_unf = 1'b1;
                      else begin a = stk.pop_back(); b = stk.pop_back(); stk.push_back(a); stk.push_back(b); end
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic rst, input logic [2:0] o, input logic [WIDTH-1:0] d);
        exp_t e;
        int   n;
        reset    = rst;
        stack_op = o;
        din      = d;
        model(rst, o, d);
        n        = stk.size();
        e.top    = (n >= 1) ? stk[n-1] : '0;
        e.second = (n >= 2) ? stk[n-2] : '0;
        e.count  = n;
        e.empty  = (n == 0);
        e.full   = (n == DEPTH);
        e.ovf    = m_ovf;
        e.unf    = m_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_top", 32'(top), 32'(e.top));
        chk("sb_second", 32'(second), 32'(e.second));
        chk("sb_count", 32'(count), 32'(e.count));
        chk("sb_empty", 32'(empty), 32'(e.empty));
        chk("sb_full", 32'(full), 32'(e.full));
        chk("sb_overflow", 32'(overflow), 32'(e.ovf));
        chk("sb_underflow", 32'(underflow), 32'(e.unf));
        @(negedge clk);
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        reset    = 1'b0;
        stack_op = 3'd0;
        din      = '0;
        @(negedge clk);
        step(1'b0, 3'd0, 16'h0);
        step(1'b0, 3'd1, 16'h1234);
        chk("rst_count", 32'(count), 0);
        chk("rst_top", 32'(top), 0);
        chk("rst_empty", 32'(empty), 1);

        // push, push, swap
        step(1'b1, 3'd1, 16'd5);
        step(1'b1, 3'd1, 16'd7);
        chk("t1_top", 32'(top), 7);
        chk("t1_second", 32'(second), 5);
        chk("t1_count", 32'(count), 2);
        step(1'b1, 3'd5, 16'd0);
        chk("t1_swap_top", 32'(top), 5);
        chk("t1_swap_second", 32'(second), 7);

        // back to (7,5), binop then pop to empty
        step(1'b1, 3'd5, 16'd0);
        step(1'b1, 3'd2, 16'd12);
        chk("t2_binop_top", 32'(top), 12);
        chk("t2_binop_second", 32'(second), 0);
        chk("t2_binop_count", 32'(count), 1);
        step(1'b1, 3'd3, 16'd0);
        chk("t2_pop_count", 32'(count), 0);
        chk("t2_pop_empty", 32'(empty), 1);
        chk("t2_pop_top", 32'(top), 0);

        // fill, overflow, drain
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 3'd1, 16'(i));
        chk("t3_full", 32'(full), 1);
        chk("t3_top", 32'(top), 16);
        chk("t3_second", 32'(second), 15);
        step(1'b1, 3'd1, 16'd99);
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_ovf_top", 32'(top), 16);
        chk("t3_ovf_count", 32'(count), 16);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 3'd3, 16'd0);
            chk("t3_drain_top", 32'(top), (i < DEPTH) ? 32'(DEPTH - i) : 0);
        end
        chk("t3_empty", 32'(empty), 1);

        // underflow cases
        step(1'b0, 3'd0, 16'd0);
        step(1'b1, 3'd3, 16'd0);
        chk("t4_underflow", 32'(underflow), 1);
        chk("t4_count", 32'(count), 0);
        step(1'b1, 3'd1, 16'd3);
        step(1'b1, 3'd4, 16'd0);
        chk("t4_unf_sticky", 32'(underflow), 1);
        chk("t4_top", 32'(top), 3);
        chk("t4_count1", 32'(count), 1);
        step(1'b1, 3'd1, 16'd4);
        step(1'b1, 3'd4, 16'd0);
        chk("t4_pop2_count", 32'(count), 0);

        // reserved ops, reset mid-sequence
        step(1'b1, 3'd1, 16'd8);
        step(1'b1, 3'd1, 16'd9);
        step(1'b1, 3'd6, 16'd55);
        step(1'b1, 3'd7, 16'd66);
        chk("t5_rsvd_top", 32'(top), 9);
        chk("t5_rsvd_second", 32'(second), 8);
        chk("t5_rsvd_count", 32'(count), 2);
        step(1'b0, 3'd1, 16'd77);
        chk("t5_rst_count", 32'(count), 0);
        chk("t5_rst_top", 32'(top), 0);
        chk("t5_rst_flags", 32'({overflow, underflow}), 0);
        step(1'b1, 3'd1, 16'd42);
        chk("t5_after_rst", 32'(top), 42);

        // random mix across the whole depth range
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 99) != 0), 3'($urandom_range(0, 7)), 16'($urandom));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
